// File: rtl/rr_seq_detect_sched.sv
// Round-robin time-shares one "01" detector across N serial requesters, with per-channel history.
// 1-cycle request-to-grant and bit-to-match latency; a requester stalls simply by holding req low.
module rr_seq_detect_sched #(
  parameter int N     = 4,
  parameter int BURST = 4,
  localparam int CW   = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  gnt,
  output logic          busy,
  output logic          y,
  output logic [CW-1:0] y_ch
);

  localparam int CNTW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [CW-1:0]   cur;
  logic [CW-1:0]   last;
  logic [CNTW-1:0] cnt;
  logic [N-1:0]    prev;

  logic [CW:0]     win_idle;
  logic [CW:0]     win_end;
  logic            last_bit;
  logic            end_burst;

  // {found, index} of the first requester strictly after 'after', wrapping; 'after' itself is checked last.
  function automatic logic [CW:0] pick(input logic [N-1:0] r, input logic [CW-1:0] after);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(after) + k) % N;
      if (r[idx]) res = {1'b1, idx[CW-1:0]};
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [CW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    win_idle  = pick(req, last);
    win_end   = pick(req, cur);
    last_bit  = (cnt == CNTW'(BURST - 1));
    end_burst = !req[cur] || last_bit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      y     <= 1'b0;
      y_ch  <= '0;
      cnt   <= '0;
      cur   <= '0;
      last  <= CW'(N - 1);
      prev  <= '1;
    end else begin
      y <= 1'b0;
      case (state)
        IDLE: begin
          if (win_idle[CW]) begin
            state <= GRANT;
            cur   <= win_idle[CW-1:0];
            gnt   <= onehot(win_idle[CW-1:0]);
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        GRANT: begin
          if (req[cur]) begin
            y          <= ~prev[cur] & din[cur];
            y_ch       <= cur;
            prev[cur]  <= din[cur];
            if (!last_bit) cnt <= cnt + 1'b1;
          end
          // Hand-off happens on the same edge so there is no idle gap between bursts.
          if (end_burst) begin
            last <= cur;
            cnt  <= '0;
            if (win_end[CW]) begin
              cur  <= win_end[CW-1:0];
              gnt  <= onehot(win_end[CW-1:0]);
              busy <= 1'b1;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_seq_detect_sched.sv
// Bench for rr_seq_detect_sched: vector tables, corner-case sequences and random traffic vs a reference model.
module tb_rr_seq_detect_sched;

  localparam int N     = 4;
  localparam int BURST = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] din;
  logic [N-1:0] gnt;
  logic         busy;
  logic         y;
  logic [1:0]   y_ch;

  int checks   = 0;
  int failures = 0;

  rr_seq_detect_sched #(.N(N), .BURST(BURST)) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .din  (din),
    .gnt  (gnt),
    .busy (busy),
    .y    (y),
    .y_ch (y_ch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: which channel holds the grant (-1 = none), bits used, history per channel.
  int m_gch;
  int m_used;
  int m_last;
  int m_prev [N];
  int m_y;
  int m_ych;

  function automatic int next_after(input logic [N-1:0] r, input int a);
    for (int k = 1; k <= N; k++) begin
      if (r[(a + k) % N]) return (a + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gch  = -1;
    m_used = 0;
    m_last = N - 1;
    m_y    = 0;
    m_ych  = 0;
    for (int i = 0; i < N; i++) m_prev[i] = 1;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
    int c;
    bit done;
    m_y  = 0;
    done = 0;
    if (m_gch < 0) begin
      if (r != 0) begin
        m_gch  = next_after(r, m_last);
        m_used = 0;
      end
    end else begin
      c = m_gch;
      if (r[c]) begin
        m_y       = (m_prev[c] == 0 && d[c] == 1'b1) ? 1 : 0;
        m_ych     = c;
        m_prev[c] = d[c] ? 1 : 0;
        m_used++;
        if (m_used == BURST) done = 1;
      end else begin
        done = 1;
      end
      if (done) begin
        m_last = c;
        m_gch  = next_after(r, c);
        m_used = 0;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply one clock edge with the given inputs and compare all outputs with the model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    int eg;
    req = r;
    din = d;
    model_edge(r, d);
    @(posedge clk);
    #1;
    eg = (m_gch < 0) ? 0 : (1 << m_gch);
    chk("model_gnt", int'(gnt), eg);
    chk("model_busy", int'(busy), (m_gch < 0) ? 0 : 1);
    chk("model_y", int'(y), m_y);
    chk("model_y_ch", int'(y_ch), m_ych);
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    @(negedge clk);
    req   = r;
    din   = '0;
    reset = 1'b0;
    #1;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_y_ch", int'(y_ch), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [N-1:0] din;
    logic [N-1:0] gnt;
    bit           y;
    logic [1:0]   ych;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit rst, input logic [N-1:0] r, input logic [N-1:0] d,
                              input logic [N-1:0] g, input bit yy, input logic [1:0] ych);
    vec_t v;
    v.rst = rst; v.req = r; v.din = d; v.gnt = g; v.y = yy; v.ych = ych;
    return v;
  endfunction

  initial begin
    logic [N-1:0] rr;
    logic [N-1:0] dd;

    // Single channel: grant edge, then bits 1,0,1,0,1,0,1,0, then release.
    tbl.push_back(mk(1, 4'b0001, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 1, 0));
    tbl.push_back(mk(0, 4'b0001, 4'b0000, 4'b0001, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0));
    // Rotation with all requesting: 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001.
    for (int k = 0; k < 17; k++)
      tbl.push_back(mk(k == 0, 4'b1111, 4'b0000, 4'(1 << ((k / 4) % 4)), 0, 0));

    reset = 1'b0;
    req   = 4'b1111;
    din   = '0;
    model_reset();

    // Power-on reset with all requesting.
    #2;
    chk("por_gnt", int'(gnt), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_y", int'(y), 0);
    chk("por_y_ch", int'(y_ch), 0);
    @(negedge clk);
    reset = 1'b1;
    step(4'b1111, 4'b0000);
    chk("first_gnt", int'(gnt), 4'b0001);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(4'b0000);
      step(tbl[i].req, tbl[i].din);
      chk($sformatf("tbl%0d_gnt", i), int'(gnt), int'(tbl[i].gnt));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].gnt != 0));
      chk($sformatf("tbl%0d_y", i), int'(y), int'(tbl[i].y));
      if (tbl[i].y) chk($sformatf("tbl%0d_ych", i), int'(y_ch), int'(tbl[i].ych));
    end

    // Context preserved across interleaving: ch1 ends burst on 0, ch2 all ones, ch1 resumes with 1.
    do_reset(4'b0000);
    step(4'b0110, 4'b0000);
    step(4'b0110, 4'b0110);
    step(4'b0110, 4'b0110);
    step(4'b0110, 4'b0110);
    step(4'b0110, 4'b0100);
    chk("ctx_handoff", int'(gnt), 4'b0100);
    for (int k = 0; k < 4; k++) begin
      step(4'b0110, 4'b0110);
      chk("ctx_ch2_nopulse", int'(y), 0);
    end
    chk("ctx_back_to_ch1", int'(gnt), 4'b0010);
    step(4'b0110, 4'b0110);
    chk("ctx_y", int'(y), 1);
    chk("ctx_y_ch", int'(y_ch), 1);

    // Early release: ch0 drops req after two samples.
    do_reset(4'b0000);
    step(4'b0101, 4'b0000);
    step(4'b0101, 4'b0000);
    step(4'b0101, 4'b0001);
    chk("er_y_before", int'(y), 1);
    step(4'b0100, 4'b0001);
    chk("er_gnt", int'(gnt), 4'b0100);
    chk("er_y", int'(y), 0);
    for (int k = 0; k < 4; k++) step(4'b0101, 4'b0000);
    chk("er_back_ch0", int'(gnt), 4'b0001);
    for (int k = 0; k < 4; k++) begin
      chk("er_full_burst", int'(gnt), 4'b0001);
      step(4'b0101, 4'b0000);
    end
    chk("er_after_burst", int'(gnt), 4'b0100);

    // Mid-burst reset on channel 3 with history 0.
    do_reset(4'b0000);
    step(4'b1000, 4'b0000);
    step(4'b1000, 4'b0000);
    step(4'b1000, 4'b1000);
    chk("mr_y_pre", int'(y), 1);
    step(4'b1000, 4'b0000);
    #3;
    reset = 1'b0;
    #1;
    chk("mr_gnt", int'(gnt), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_y_ch", int'(y_ch), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    step(4'b1000, 4'b0000);
    chk("mr_regrant", int'(gnt), 4'b1000);
    step(4'b1000, 4'b1000);
    chk("mr_no_y", int'(y), 0);

    // Random traffic against the model.
    do_reset(4'b0000);
    for (int k = 0; k < 600; k++) begin
      rr = 4'($urandom_range(0, 15));
      dd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && k > 0) rr = req | rr & 4'($urandom_range(0, 15));
      step(rr, dd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_seq_detect_sched.md
# rr_seq_detect_sched

Round-robin scheduler that time-shares a single "01" serial sequence detector among N bit-stream requesters. Each requester gets bursts of up to BURST bits. The block keeps a per-channel history bit, so detection is continuous per channel across burst boundaries and interleaving. It sits between the serial sources and the match-reporting logic, and replaces one detector instance per source.

## Interface
- N, default 4: number of requesters. Legal range 2..16.
- BURST, default 4: maximum bits sampled per grant. Legal range 1..16.
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset. Asserted when 0.
- req, input, N: req[i]=1 means requester i has bits to send. Held while bits remain.
- din, input, N: din[i] is requester i's serial bit. Sampled only while granted.
- gnt, output, N: one-hot grant, or all zero. Registered.
- busy, output, 1: equals |gnt. Registered.
- y, output, 1: one-cycle match pulse. Registered.
- y_ch, output, clog2(N): channel index for the current y pulse. Registered.

## Operation
- Registered state:
  - state: IDLE or GRANT.
  - gnt, cur (granted index), cnt (0..BURST-1), last (last granted index).
  - prev[N]: per-channel history bit.
  - y, y_ch.
- Reset values: state=IDLE, gnt=0, busy=0, y=0, y_ch=0, cnt=0, cur=0, last=N-1 (channel 0 wins first), prev[i]=1 for all i (no 0 seen yet).
- Winner selection: the first set bit in req, scanning from (last+1) mod N upward and wrapping. The channel just served is checked last.
- IDLE:
  - gnt=0.
  - If |req, then next edge: state=GRANT, cur=winner, gnt=onehot(winner), cnt=0.
- GRANT, at each edge:
  - If req[cur]=1, sample the channel:
    - y<=(prev[cur]==0 && din[cur]==1).
    - y_ch<=cur.
    - prev[cur]<=din[cur].
    - If cnt==BURST-1, end the burst; otherwise cnt<=cnt+1.
  - If req[cur]=0 (early release): no sample, y<=0, prev unchanged, end the burst.
- End of burst, in the same edge:
  - last<=cur.
  - Recompute the winner from (cur+1) using the current req.
  - If a winner exists: stay in GRANT with gnt=onehot(winner), cnt=0, and no idle gap. This may re-grant cur if it is the sole requester with req[cur]=1.
  - Otherwise: state=IDLE, gnt=0.
- Overlapping detection: the bit stream 0,1,0,1 produces two matches.
- Ungranted channels: din is ignored and prev is held. Req toggling on an ungranted channel has no effect until arbitration.
- y=0 on every cycle with no qualifying sample.
- Reset mid-burst: all registers take reset values immediately. An in-flight burst is discarded and histories are cleared.

## Timing
- Request to grant: req[i] rises while IDLE → gnt[i]=1 after the next rising edge (1 cycle).
- Bit consumption: a bit is consumed at each rising edge where gnt[i]=1 and req[i]=1. The requester presents a new din[i] after each such edge.
- Match output: y is visible in the cycle following the edge that sampled the 1 completing "01".
- Grant hand-off: gnt changes one-hot to one-hot on the edge ending a burst, with no all-zero cycle, when another request is pending.
- Maximum grant length: BURST cycles while req is held. Early release ends the grant at the first edge that sees req[cur]=0.
- Reset: asynchronous assertion clears outputs without waiting for clk. Deassertion is synchronous to clk externally. The first arbitration happens at the first edge after release.

## Test plan
- **Reset:** reset=0 with req=4'b1111 → gnt=0, busy=0, y=0, y_ch=0 immediately. After release, gnt=4'b0001 at the first edge.
- **Single channel continuous:** req=4'b0001 held, din[0]=1,0,1,0,1,0,1,0 on consecutive bit cycles.
  - gnt stays 4'b0001 for all 8 cycles, with back-to-back re-grant.
  - y pulses after bits 3, 5 and 7 with y_ch=0. No pulse after bit 1.
- **Round-robin rotation:** req=4'b1111 held, BURST=4 → gnt sequence is 0001×4, 0010×4, 0100×4, 1000×4, 0001… with busy=1 throughout.
- **Context preserved:** req=4'b0110.
  - Channel 1's last bit of its burst is 0, then channel 2 gets its burst.
  - Channel 1's next burst starts with 1 → y=1 with y_ch=1 on that sample.
  - Channel 2 data (all 1s) never pulses.
- **Early release:** req=4'b0101, channel 0 drops req after 2 samples → gnt=4'b0100 at the edge seeing req[0]=0. No sample or y on that edge, and channel 0's cnt is not carried over.
- **Mid-burst reset:** channel 3 has sent 0 (prev[3]=0) and is mid-burst; pulse reset low.
  - Outputs go to 0 immediately.
  - After release and re-grant, a first bit of 1 on channel 3 → no y, because prev was reset to 1.
